uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Configurable UART transmitter: serialises one 5..8-bit word per start request, with optional
//  even/odd parity and 1, 1.5 or 2 stop bits, at a selectable baud rate.
//  Feeds the pad-side TX line of the APB UART; the register block drives its config inputs.
// PARAMETERS
//  SYSTEM_FREQUENCY  10_000_000  clk frequency in Hz
//  SAMPLING_RATE     16          baud ticks per bit (oversampling factor shared with RX)
// PORTS
//  clk           in   1  system clock, all logic rising-edge
//  reset_n       in   1  asynchronous active-low reset
//  data_i        in   8  word to send; only low N bits used, N per data_bit_num
//  tx_en_i       in   1  transmitter enable
//  start_tx_i    in   1  start request, 1-cycle pulse
//  baud_sl_i     in   3  baud select
//  stop_bit_num  in   2  00=1, 01=1.5, 10=2, 11=2 stop bits
//  data_bit_num  in   2  00=5, 01=6, 10=7, 11=8 data bits
//  parity_en_i   in   1  1 = append parity bit
//  parity_type   in   1  1 = even, 0 = odd
//  tx_o          out  1  serial line, idle high
//  trans_fi_o    out  1  frame-done pulse
// BEHAVIOUR
//  - Reset: tx_o=1, trans_fi_o=0, FSM=IDLE, counters cleared.
//  - Baud select: 000=4800, 001=9600, 010=19200, 011=38400, 100=57600, 101/110/111=115200.
//  - Divider: DIV = SYSTEM_FREQUENCY/(baud*SAMPLING_RATE), integer floor, min 1.
//    One tick every DIV clk. One bit = SAMPLING_RATE ticks; 1.5 stop = 1.5*SAMPLING_RATE ticks.
//  - Start acceptance: start_tx_i is accepted only in IDLE with tx_en_i=1.
//    - On acceptance, latch data_i, data_bit_num, stop_bit_num, parity_en_i, parity_type and baud_sl_i.
//    - Divider and tick counters restart, so every bit lasts exactly SAMPLING_RATE*DIV clk.
//    - start_tx_i while busy or with tx_en_i=0 is ignored.
//  - FSM: IDLE -> START (tx_o=0) -> DATA (N bits, LSB first) -> PARITY (if enabled) -> STOP
//    (tx_o=1) -> DONE -> IDLE.
//    - tx_o goes low on the clk after acceptance.
//    - Frame length = (1 + N + P + S) bit times.
//  - Parity bit: even = XOR of the N sent bits; odd = its inverse. Bits above N are excluded.
//  - trans_fi_o: high for exactly 1 clk at the DONE state, i.e. the cycle after the last stop
//    tick. tx_o stays 1.
//    - A new start may be accepted on the cycle after the pulse.
//  - tx_en_i deasserted mid-frame: abort.
//    - FSM goes to IDLE and tx_o=1 on the next clk.
//    - trans_fi_o is not pulsed.
//  - Config or data_i changes mid-frame have no effect; the latched copies are used.
//  - tx_o is registered, with no combinational path from inputs.
// TESTING
//  (SYSTEM_FREQUENCY=10e6, 9600 baud gives DIV=65, bit = 1040 clk)
//  - 0x6A, 7 bits, no parity, 1 stop -> tx_o = 0,0,1,0,1,0,1,1,1 (9 bits x 1040 clk); one
//    trans_fi_o pulse.
//  - 0xAB, 8 bits, no parity, 1 stop -> 0,1,1,0,1,0,1,0,1,1; then idle high.
//  - 0x6B, 8 bits, even parity, 1 stop -> data 1,1,0,1,0,1,1,0; parity=1; stop 1; 11 bits total.
//  - 0x6B, 8 bits, odd parity, 2 stop -> parity=0, two stop bits, 12 bits; pulse 1 clk after
//    the last stop tick.
//  - Other field encodings:
//    - 0x0A, 5 bits, 1.5 stop -> 0,0,1,0,1,0 then 1.5 bit times of 1.
//    - start_tx_i pulsed mid-frame -> ignored, no extra frame.
//  - Drop tx_en_i mid-DATA -> tx_o=1 next clk, no trans_fi_o.
//    - Assert reset_n=0 mid-frame -> outputs at reset values immediately.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: configurable UART transmitter.
// Sends one 5..8-bit word per accepted start request, LSB first, with optional
// even/odd parity and 1, 1.5 or 2 stop bits. The baud tick is derived from the
// system clock by an integer divider. Every bit lasts SAMPLING_RATE ticks.
module uart_tx #(
  parameter int SYSTEM_FREQUENCY = 10_000_000,
  parameter int SAMPLING_RATE    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_i,
  input  logic       tx_en_i,
  input  logic       start_tx_i,
  input  logic [2:0] baud_sl_i,
  input  logic [1:0] stop_bit_num,
  input  logic [1:0] data_bit_num,
  input  logic       parity_en_i,
  input  logic       parity_type,
  output logic       tx_o,
  output logic       trans_fi_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_e;

  // The tick counter must reach 2*SAMPLING_RATE-1 for two stop bits.
  localparam int TW = $clog2(2 * SAMPLING_RATE);
  localparam logic [TW-1:0] BIT_LAST    = TW'(SAMPLING_RATE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(SAMPLING_RATE + SAMPLING_RATE / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * SAMPLING_RATE - 1);

  // Terminal count of the clk-to-tick divider for a baud select code.
  function automatic logic [15:0] div_last(input logic [2:0] sel);
    int baud;
    int div;
    case (sel)
      3'b000:  baud = 4800;
      3'b001:  baud = 9600;
      3'b010:  baud = 19200;
      3'b011:  baud = 38400;
      3'b100:  baud = 57600;
      default: baud = 115200;
    endcase
    div = SYSTEM_FREQUENCY / (baud * SAMPLING_RATE);
    if (div < 1) div = 1;
    return 16'(div - 1);
  endfunction

  // Mask selecting the low N data bits for a word-length code.
  function automatic logic [7:0] width_mask(input logic [1:0] n);
    case (n)
      2'b00:   return 8'h1F;
      2'b01:   return 8'h3F;
      2'b10:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic            tx_q, tx_d;
  logic            fi_q, fi_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [15:0]     div_last_q, div_last_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      dbn_q, dbn_d;
  logic [1:0]      sbn_q, sbn_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;

  logic            tick;
  logic            bit_end;
  logic [TW-1:0]   stop_last;
  logic [TW-1:0]   tick_last;
  logic [2:0]      data_last;

  // Baud tick, end of the current bit slot and index of the last data bit.
  always_comb begin
    tick = (div_cnt_q == div_last_q);
    case (sbn_q)
      2'b00:   stop_last = BIT_LAST;
      2'b01:   stop_last = STOP15_LAST;
      default: stop_last = STOP2_LAST;
    endcase
    tick_last = (state_q == S_STOP) ? stop_last : BIT_LAST;
    bit_end   = tick && (tick_cnt_q == tick_last);
    data_last = 3'd4 + {1'b0, dbn_q};
  end

  // Frame sequencing: next state, next line level and latched frame settings.
  always_comb begin
    logic [2:0] next_idx;
    // NOTE: every _d starts from its _q (fi_d from 0) so that no branch of the
    // case leaves a variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    tx_d       = tx_q;
    fi_d       = 1'b0;
    div_cnt_d  = div_cnt_q;
    div_last_d = div_last_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    dbn_d      = dbn_q;
    sbn_d      = sbn_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    next_idx   = bit_idx_q + 3'd1;

    if (state_q != S_IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 16'd1;
      if (bit_end) begin
        tick_cnt_d = '0;
      end else if (tick) begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        div_cnt_d  = '0;
        tick_cnt_d = '0;
        if (tx_en_i && start_tx_i) begin
          state_d    = S_START;
          tx_d       = 1'b0;
          data_d     = data_i;
          dbn_d      = data_bit_num;
          sbn_d      = stop_bit_num;
          par_en_d   = parity_en_i;
          // Even parity is the XOR of the sent bits; odd parity is its inverse.
          par_bit_d  = (^(data_i & width_mask(data_bit_num))) ^ ~parity_type;
          div_last_d = div_last(baud_sl_i);
          bit_idx_d  = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == data_last) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = next_idx;
            tx_d      = data_q[next_idx];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_DONE;
          tx_d    = 1'b1;
          fi_d    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Dropping the enable mid-frame abandons the frame without a done pulse.
    if (!tx_en_i && (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})) begin
      state_d    = S_IDLE;
      tx_d       = 1'b1;
      fi_d       = 1'b0;
      div_cnt_d  = '0;
      tick_cnt_d = '0;
    end
  end

  // State, line and frame-setting registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values and the update order inside the block does not matter.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      fi_q       <= 1'b0;
      div_cnt_q  <= '0;
      div_last_q <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      dbn_q      <= '0;
      sbn_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      fi_q       <= fi_d;
      div_cnt_q  <= div_cnt_d;
      div_last_q <= div_last_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      dbn_q      <= dbn_d;
      sbn_q      <= sbn_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
    end
  end

  assign tx_o       = tx_q;
  assign trans_fi_o = fi_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames with literal bit patterns, plus a per-cycle
// waveform model of the serial line and done pulse compared on every cycle.
module tb_uart_tx;

  localparam int SYS = 10_000_000;
  localparam int SR  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data_i = '0;
  logic       tx_en_i = 1'b1;
  logic       start_tx_i = 1'b0;
  logic [2:0] baud_sl_i = '0;
  logic [1:0] stop_bit_num = '0;
  logic [1:0] data_bit_num = '0;
  logic       parity_en_i = 1'b0;
  logic       parity_type = 1'b0;
  logic       tx_o;
  logic       trans_fi_o;

  always #5 clk = ~clk;

  uart_tx #(.SYSTEM_FREQUENCY(SYS), .SAMPLING_RATE(SR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_i       (data_i),
    .tx_en_i      (tx_en_i),
    .start_tx_i   (start_tx_i),
    .baud_sl_i    (baud_sl_i),
    .stop_bit_num (stop_bit_num),
    .data_bit_num (data_bit_num),
    .parity_en_i  (parity_en_i),
    .parity_type  (parity_type),
    .tx_o         (tx_o),
    .trans_fi_o   (trans_fi_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Clocks per tick for a baud select code, straight from the baud table.
  function automatic int div_of(input logic [2:0] sel);
    int baud;
    int div;
    case (sel)
      3'b000:  baud = 4800;
      3'b001:  baud = 9600;
      3'b010:  baud = 19200;
      3'b011:  baud = 38400;
      3'b100:  baud = 57600;
      default: baud = 115200;
    endcase
    div = SYS / (baud * SR);
    if (div < 1) div = 1;
    return div;
  endfunction

  function automatic int bit_len(input logic [2:0] sel);
    return SR * div_of(sel);
  endfunction

  // Expected waveform: one {tx, done} entry per clk, starting at acceptance.
  logic [1:0] exp_q[$];
  logic       exp_tx = 1'b1;
  logic       exp_fi = 1'b0;

  function automatic void push_frame(input logic [7:0] d, input logic [1:0] dbn,
                                     input logic [1:0] sbn, input logic pen,
                                     input logic ptype, input logic [2:0] sel);
    int   n = 5 + int'(dbn);
    int   len = bit_len(sel);
    int   stop_cycles;
    logic p = 1'b0;
    repeat (len) exp_q.push_back(2'b00);
    for (int i = 0; i < n; i++) begin
      repeat (len) exp_q.push_back({d[i], 1'b0});
      p = p ^ d[i];
    end
    if (pen) begin
      if (!ptype) p = ~p;
      repeat (len) exp_q.push_back({p, 1'b0});
    end
    stop_cycles = (sbn == 2'b00) ? len : (sbn == 2'b01) ? len + len / 2 : 2 * len;
    repeat (stop_cycles) exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
  endfunction

  // Model: busy while waveform entries remain or during the done cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_tx <= 1'b1;
      exp_fi <= 1'b0;
    end else begin
      if (exp_q.size() != 0 && !tx_en_i) begin
        exp_q.delete();
      end else if (exp_q.size() == 0 && !exp_fi && tx_en_i && start_tx_i) begin
        push_frame(data_i, data_bit_num, stop_bit_num, parity_en_i, parity_type, baud_sl_i);
      end
      if (exp_q.size() != 0) begin
        exp_tx <= exp_q[0][1];
        exp_fi <= exp_q[0][0];
        void'(exp_q.pop_front());
      end else begin
        exp_tx <= 1'b1;
        exp_fi <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_tx_o", tx_o, exp_tx);
      check("model_trans_fi_o", trans_fi_o, exp_fi);
    end
  end

  task automatic advance(inout int e, input int target);
    while (e < target) begin
      @(posedge clk);
      e++;
    end
    @(negedge clk);
  endtask

  // Send one frame, check literal mid-bit levels and the exact done-pulse cycle.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] dbn, input logic [1:0] sbn,
                           input logic pen, input logic ptype, input logic [2:0] sel,
                           input logic [15:0] bits, input int nbits, input int len_x2,
                           input bit mid_start);
    int len = bit_len(sel);
    int t_end = len_x2 * len / 2;
    int e = 0;
    @(posedge clk);
    #1;
    data_i = d; data_bit_num = dbn; stop_bit_num = sbn;
    parity_en_i = pen; parity_type = ptype; baud_sl_i = sel;
    start_tx_i = 1'b1;
    @(posedge clk);
    #1;
    start_tx_i = 1'b0;
    // Scramble everything: the frame must use the latched copies.
    data_i = ~d; data_bit_num = ~dbn; stop_bit_num = ~sbn;
    parity_en_i = ~pen; parity_type = ~ptype; baud_sl_i = ~sel;
    for (int i = 0; i < nbits; i++) begin
      advance(e, i * len + len / 2);
      check("frame_bit", tx_o, bits[i]);
      if (mid_start && i == 2) begin
        start_tx_i = 1'b1;
        @(posedge clk);
        e++;
        #1;
        start_tx_i = 1'b0;
      end
    end
    advance(e, t_end - 1);
    check("done_early", trans_fi_o, 1'b0);
    advance(e, t_end);
    check("done_pulse", trans_fi_o, 1'b1);
    check("done_tx_idle", tx_o, 1'b1);
    // A start during the done cycle is too early and must be ignored.
    start_tx_i = 1'b1;
    @(posedge clk);
    e++;
    #1;
    start_tx_i = 1'b0;
    @(negedge clk);
    check("done_one_cycle", trans_fi_o, 1'b0);
    check("after_done_tx", tx_o, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    @(negedge clk);
    check("reset_tx", tx_o, 1'b1);
    check("reset_fi", trans_fi_o, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // 9600 baud, 7 bits 0x6A: 0,0,1,0,1,0,1,1,1
    run_frame(8'h6A, 2'b10, 2'b00, 1'b0, 1'b0, 3'b001, 16'h01D4, 9, 18, 1'b0);
    // 115200, 8 bits 0xAB: 0,1,1,0,1,0,1,0,1,1 with a stray start mid-frame
    run_frame(8'hAB, 2'b11, 2'b00, 1'b0, 1'b0, 3'b101, 16'h0356, 10, 20, 1'b1);
    // 57600, 0x6B even parity: parity 1, 11 bits
    run_frame(8'h6B, 2'b11, 2'b00, 1'b1, 1'b1, 3'b100, 16'h06D6, 11, 22, 1'b0);
    // 115200, 0x6B odd parity, 2 stop: parity 0, 12 bits
    run_frame(8'h6B, 2'b11, 2'b10, 1'b1, 1'b0, 3'b111, 16'h0CD6, 12, 24, 1'b0);
    // 38400, 0x0A 5 bits, 1.5 stop: 0,0,1,0,1,0 then 1.5 bits of 1
    run_frame(8'h0A, 2'b00, 2'b01, 1'b0, 1'b0, 3'b011, 16'h0054, 7, 15, 1'b0);
    // 115200, 0xE5 5 bits even parity, stop code 11: upper bits excluded, parity 0
    run_frame(8'hE5, 2'b00, 2'b11, 1'b1, 1'b1, 3'b110, 16'h018A, 9, 18, 1'b0);

    // Start with the transmitter disabled is ignored.
    @(posedge clk);
    #1;
    tx_en_i = 1'b0;
    start_tx_i = 1'b1;
    @(posedge clk);
    #1;
    start_tx_i = 1'b0;
    @(negedge clk);
    check("disabled_start_tx", tx_o, 1'b1);
    #1;
    tx_en_i = 1'b1;
    repeat (200) @(posedge clk);

    // Drop the enable in the middle of the data bits of an all-zero word.
    #1;
    data_i = 8'h00; data_bit_num = 2'b11; stop_bit_num = 2'b00;
    parity_en_i = 1'b0; baud_sl_i = 3'b101;
    start_tx_i = 1'b1;
    @(posedge clk);
    #1;
    start_tx_i = 1'b0;
    repeat (3 * 80) @(posedge clk);
    #1;
    check("pre_abort_tx_low", tx_o, 1'b0);
    tx_en_i = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx", tx_o, 1'b1);
    check("abort_fi", trans_fi_o, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    tx_en_i = 1'b1;
    repeat (1000) @(posedge clk);

    // Asynchronous reset in the middle of a frame.
    #1;
    start_tx_i = 1'b1;
    @(posedge clk);
    #1;
    start_tx_i = 1'b0;
    repeat (2 * 80) @(posedge clk);
    @(negedge clk);
    #2;
    check("pre_reset_tx_low", tx_o, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_tx", tx_o, 1'b1);
    check("midreset_fi", trans_fi_o, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (1000) @(posedge clk);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
